// File: rtl/fpnew_pipe_skid.sv
// Elastic FPU operation pipeline with bubble collapse, optional per-stage skid buffers,
// flush and tag-selective kill, and a registered occupancy count.

module fpnew_pipe_skid_chk #(
  parameter int unsigned DataWidth = 96,
  parameter int unsigned CntWidth  = 2,
  parameter int unsigned Capacity  = 2
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 flush,
  input logic                 kill_valid,
  input logic                 out_valid,
  input logic                 out_ready,
  input logic [DataWidth-1:0] out_data,
  input logic [CntWidth-1:0]  occupancy
);
  occ_range: assert property (@(posedge clk) disable iff (rst) int'(occupancy) <= int'(Capacity));
  // A held output only changes when flush or kill may remove it.
  out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush && !kill_valid) |=> $stable(out_data));
endmodule

module fpnew_pipe_skid #(
  parameter int unsigned DataWidth   = 96,
  parameter int unsigned TagWidth    = 4,
  parameter int unsigned NumPipeRegs = 2,
  parameter bit          CutReady    = 1'b0,
  localparam int unsigned Capacity   = NumPipeRegs * (CutReady ? 32'd2 : 32'd1),
  // Width kept at least 1 so the feed-through configuration still has a legal port.
  localparam int unsigned CntWidth   = (Capacity == 0) ? 1 : $clog2(Capacity + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic [TagWidth-1:0]  in_tag_i,
  input  logic                 flush_i,
  input  logic                 kill_valid_i,
  input  logic [TagWidth-1:0]  kill_tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic [TagWidth-1:0]  out_tag_o,
  output logic [CntWidth-1:0]  occupancy_o,
  output logic                 busy_o
);
  assign busy_o = in_valid_i | (occupancy_o != '0);

  if (NumPipeRegs == 0) begin : g_bypass
    assign in_ready_o  = out_ready_i;
    assign out_valid_o = in_valid_i & ~flush_i & ~(kill_valid_i & (in_tag_i == kill_tag_i));
    assign out_data_o  = in_data_i;
    assign out_tag_o   = in_tag_i;
    assign occupancy_o = '0;
  end else begin : g_pipe
    localparam int unsigned N = NumPipeRegs;

    logic [N-1:0]         main_v, skid_v, main_v_n, skid_v_n;
    logic [N-1:0]         main_ld, main_from_skid, skid_ld, up_v;
    logic [N:0]           rdy;
    logic [DataWidth-1:0] main_d [N];
    logic [DataWidth-1:0] skid_d [N];
    logic [DataWidth-1:0] up_d   [N];
    logic [TagWidth-1:0]  main_t [N];
    logic [TagWidth-1:0]  skid_t [N];
    logic [TagWidth-1:0]  up_t   [N];
    logic [CntWidth-1:0]  cnt, cnt_n;

    assign up_v[0] = in_valid_i;
    assign up_d[0] = in_data_i;
    assign up_t[0] = in_tag_i;
    for (genvar g = 1; g < N; g++) begin : g_link
      assign up_v[g] = main_v[g-1];
      assign up_d[g] = main_d[g-1];
      assign up_t[g] = main_t[g-1];
    end

    // Ready chain: with skids each stage's ready is purely registered.
    always_comb begin
      logic r;
      r      = out_ready_i;
      rdy    = '0;
      rdy[N] = out_ready_i;
      for (int i = N - 1; i >= 0; i--) begin
        if (CutReady) begin
          r = ~skid_v[i];
        end else begin
          r = r | ~main_v[i];
        end
        rdy[i] = r;
      end
    end

    // Next-state of every stage, then flush/kill masking on the new contents.
    always_comb begin
      logic acc, take;
      logic [TagWidth-1:0] mt, st;
      main_v_n       = main_v;
      skid_v_n       = skid_v;
      main_ld        = '0;
      main_from_skid = '0;
      skid_ld        = '0;
      cnt_n          = '0;
      for (int i = 0; i < N; i++) begin
        acc  = up_v[i] & rdy[i];
        take = main_v[i] & rdy[i+1];
        mt   = main_t[i];
        st   = skid_t[i];
        if (CutReady) begin
          if (take | ~main_v[i]) begin
            if (skid_v[i]) begin
              main_ld[i]        = 1'b1;
              main_from_skid[i] = 1'b1;
              main_v_n[i]       = 1'b1;
              skid_v_n[i]       = 1'b0;
              mt                = skid_t[i];
            end else begin
              main_ld[i]  = acc;
              main_v_n[i] = acc;
              mt          = up_t[i];
            end
          end else if (acc) begin
            skid_ld[i]  = 1'b1;
            skid_v_n[i] = 1'b1;
            st          = up_t[i];
          end else begin
            main_v_n[i] = main_v[i];
          end
        end else if (rdy[i]) begin
          main_ld[i]  = acc;
          main_v_n[i] = up_v[i];
          mt          = up_t[i];
        end else begin
          main_v_n[i] = main_v[i];
        end
        if (flush_i) begin
          main_v_n[i] = 1'b0;
          skid_v_n[i] = 1'b0;
        end else if (kill_valid_i) begin
          if (mt == kill_tag_i) main_v_n[i] = 1'b0;
          if (st == kill_tag_i) skid_v_n[i] = 1'b0;
        end else begin
          cnt_n = cnt_n;
        end
        cnt_n = cnt_n + CntWidth'(main_v_n[i]) + CntWidth'(skid_v_n[i]);
      end
    end

    // Valids always update; payload registers load only on an accepted beat.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        main_v <= '0;
        skid_v <= '0;
        cnt    <= '0;
        for (int i = 0; i < N; i++) begin
          main_d[i] <= '0;
          main_t[i] <= '0;
          skid_d[i] <= '0;
          skid_t[i] <= '0;
        end
      end else begin
        main_v <= main_v_n;
        skid_v <= skid_v_n;
        cnt    <= cnt_n;
        for (int i = 0; i < N; i++) begin
          if (main_ld[i]) begin
            main_d[i] <= main_from_skid[i] ? skid_d[i] : up_d[i];
            main_t[i] <= main_from_skid[i] ? skid_t[i] : up_t[i];
          end
          if (skid_ld[i]) begin
            skid_d[i] <= up_d[i];
            skid_t[i] <= up_t[i];
          end
        end
      end
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = main_v[N-1];
    assign out_data_o  = main_d[N-1];
    assign out_tag_o   = main_t[N-1];
    assign occupancy_o = cnt;

    fpnew_pipe_skid_chk #(.DataWidth(DataWidth), .CntWidth(CntWidth), .Capacity(Capacity)) u_chk (
      .clk(clk_i), .rst(rst_i), .flush(flush_i), .kill_valid(kill_valid_i),
      .out_valid(out_valid_o), .out_ready(out_ready_i), .out_data(out_data_o),
      .occupancy(occupancy_o)
    );
  end
endmodule

// File: tb/tb_fpnew_pipe_skid.sv
// Bench for fpnew_pipe_skid: three configurations (2 regs plain, 2 regs skid, feed-through)
// driven from shared stimulus, checked against constants and a queue-based reference model.
module tb_fpnew_pipe_skid;
  localparam int DW = 96;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, flush, kill_valid, out_ready;
  logic [DW-1:0] in_data;
  logic [TW-1:0] in_tag, kill_tag;

  logic a_in_ready, a_out_valid, a_busy; logic [DW-1:0] a_out_data; logic [TW-1:0] a_out_tag; logic [1:0] a_occ;
  logic b_in_ready, b_out_valid, b_busy; logic [DW-1:0] b_out_data; logic [TW-1:0] b_out_tag; logic [2:0] b_occ;
  logic z_in_ready, z_out_valid, z_busy; logic [DW-1:0] z_out_data; logic [TW-1:0] z_out_tag; logic [0:0] z_occ;

  fpnew_pipe_skid #(.DataWidth(DW), .TagWidth(TW), .NumPipeRegs(2), .CutReady(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data),
    .in_tag_i(in_tag), .flush_i(flush), .kill_valid_i(kill_valid), .kill_tag_i(kill_tag),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data), .out_tag_o(a_out_tag),
    .occupancy_o(a_occ), .busy_o(a_busy));
  fpnew_pipe_skid #(.DataWidth(DW), .TagWidth(TW), .NumPipeRegs(2), .CutReady(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_data_i(in_data),
    .in_tag_i(in_tag), .flush_i(flush), .kill_valid_i(kill_valid), .kill_tag_i(kill_tag),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data), .out_tag_o(b_out_tag),
    .occupancy_o(b_occ), .busy_o(b_busy));
  fpnew_pipe_skid #(.DataWidth(DW), .TagWidth(TW), .NumPipeRegs(0), .CutReady(1'b0)) dut_z (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(z_in_ready), .in_data_i(in_data),
    .in_tag_i(in_tag), .flush_i(flush), .kill_valid_i(kill_valid), .kill_tag_i(kill_tag),
    .out_valid_o(z_out_valid), .out_ready_i(out_ready), .out_data_o(z_out_data), .out_tag_o(z_out_tag),
    .occupancy_o(z_occ), .busy_o(z_busy));

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] dat [16];

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;
  ent_t qa[$];
  ent_t qb[$];

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; in_tag = '0; flush = 1'b0; kill_valid = 1'b0; kill_tag = '0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid a=%b b=%b want 0", a_out_valid, b_out_valid); end
    n_tests++; if (a_out_data !== '0 || b_out_data !== '0 || a_out_tag !== '0 || b_out_tag !== '0) begin n_fail++; $display("FAIL reset_out_data a=%h/%h b=%h/%h want 0", a_out_data, a_out_tag, b_out_data, b_out_tag); end
    n_tests++; if (a_occ !== 2'd0 || b_occ !== 3'd0) begin n_fail++; $display("FAIL reset_occ a=%0d b=%0d want 0", a_occ, b_occ); end
    n_tests++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready a=%b b=%b want 1", a_in_ready, b_in_ready); end
    n_tests++; if (a_busy !== 1'b1 || b_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_hi a=%b b=%b want 1", a_busy, b_busy); end
    in_valid = 1'b0; #1;
    n_tests++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_lo a=%b b=%b want 0", a_busy, b_busy); end
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      in_valid = (c < 10);
      in_tag   = TW'(c);
      in_data  = (c < 10) ? dat[c] : '0;
      @(negedge clk);
      n_tests++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready c=%0d a=%b b=%b want 1", c, a_in_ready, b_in_ready); end
      n_tests++; if (a_out_valid !== (c >= 2 && c < 12) || b_out_valid !== (c >= 2 && c < 12)) begin n_fail++; $display("FAIL stream_valid c=%0d a=%b b=%b want %b", c, a_out_valid, b_out_valid, (c >= 2 && c < 12)); end
      if (c >= 2 && c < 12) begin
        n_tests++; if (a_out_tag !== TW'(c-2) || a_out_data !== dat[c-2]) begin n_fail++; $display("FAIL stream_a_item c=%0d tag=%0d want %0d", c, a_out_tag, c-2); end
        n_tests++; if (b_out_tag !== TW'(c-2) || b_out_data !== dat[c-2]) begin n_fail++; $display("FAIL stream_b_item c=%0d tag=%0d want %0d", c, b_out_tag, c-2); end
      end
      n_tests++; if (z_out_valid !== in_valid || z_out_tag !== in_tag || z_out_data !== in_data || z_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_z c=%0d valid=%b tag=%0d want %b/%0d", c, z_out_valid, z_out_tag, in_valid, in_tag); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_fill();
    int ia, ib;
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_tag = TW'(c); in_data = dat[c];
      @(negedge clk);
      n_tests++; if (a_in_ready !== (c < 2) || b_in_ready !== (c < 4)) begin n_fail++; $display("FAIL fill_ready c=%0d a=%b b=%b want %b/%b", c, a_in_ready, b_in_ready, (c < 2), (c < 4)); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (a_occ !== 2'd2 || b_occ !== 3'd4) begin n_fail++; $display("FAIL fill_occ a=%0d b=%0d want 2/4", a_occ, b_occ); end
    n_tests++; if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready a=%b b=%b want 0", a_in_ready, b_in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    ia = 0; ib = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (a_out_valid) begin
        n_tests++; if (ia >= 2 || a_out_tag !== TW'(ia) || a_out_data !== dat[ia & 15]) begin n_fail++; $display("FAIL drain_a idx=%0d tag=%0d", ia, a_out_tag); end
        ia++;
      end
      if (b_out_valid) begin
        n_tests++; if (ib >= 4 || b_out_tag !== TW'(ib) || b_out_data !== dat[ib & 15]) begin n_fail++; $display("FAIL drain_b idx=%0d tag=%0d", ib, b_out_tag); end
        ib++;
      end
      @(posedge clk); #1;
    end
    n_tests++; if (ia != 2 || ib != 4) begin n_fail++; $display("FAIL drain_count a=%0d b=%0d want 2/4", ia, ib); end
    n_tests++; if (a_occ !== 2'd0 || b_occ !== 3'd0) begin n_fail++; $display("FAIL drain_occ a=%0d b=%0d want 0", a_occ, b_occ); end
  endtask

  task automatic test_bubble_collapse();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 4'd6; in_data = dat[6];
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bubble_s0_ready got %b want 1", a_in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (a_out_valid !== 1'b1 || a_out_tag !== 4'd6 || a_out_data !== dat[6]) begin n_fail++; $display("FAIL bubble_out valid=%b tag=%0d want 1/6", a_out_valid, a_out_tag); end
    n_tests++; if (a_in_ready !== 1'b1 || a_occ !== 2'd1) begin n_fail++; $display("FAIL bubble_ready ready=%b occ=%0d want 1/1", a_in_ready, a_occ); end
  endtask

  task automatic test_kill();
    logic [TW-1:0] tags [4];
    int eb [2];
    int ia, ib;
    tags = '{4'd3, 4'd5, 4'd3, 4'd7};
    eb = '{1, 3};
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_tag = tags[c]; in_data = dat[c + 8];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (a_occ !== 2'd2 || b_occ !== 3'd4) begin n_fail++; $display("FAIL kill_pre_occ a=%0d b=%0d want 2/4", a_occ, b_occ); end
    @(posedge clk); #1;
    kill_valid = 1'b1; kill_tag = 4'd3;
    @(posedge clk); #1;
    kill_valid = 1'b0;
    n_tests++; if (a_occ !== 2'd1 || b_occ !== 3'd2) begin n_fail++; $display("FAIL kill_post_occ a=%0d b=%0d want 1/2", a_occ, b_occ); end
    out_ready = 1'b1;
    ia = 0; ib = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_out_valid) begin
        n_tests++; if (ia >= 1 || a_out_tag !== 4'd5 || a_out_data !== dat[9]) begin n_fail++; $display("FAIL kill_a idx=%0d tag=%0d want 5", ia, a_out_tag); end
        ia++;
      end
      if (b_out_valid) begin
        n_tests++; if (ib >= 2 || b_out_tag !== tags[eb[ib & 1]] || b_out_data !== dat[eb[ib & 1] + 8]) begin n_fail++; $display("FAIL kill_b idx=%0d tag=%0d", ib, b_out_tag); end
        ib++;
      end
      @(posedge clk); #1;
    end
    n_tests++; if (ia != 1 || ib != 2) begin n_fail++; $display("FAIL kill_count a=%0d b=%0d want 1/2", ia, ib); end
  endtask

  task automatic test_flush_kill();
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_tag = TW'(c + 1); in_data = dat[c];
      @(posedge clk); #1;
    end
    in_tag = 4'd1; in_data = dat[5]; flush = 1'b1; kill_valid = 1'b1; kill_tag = 4'd1;
    @(negedge clk);
    n_tests++; if (a_in_ready !== 1'b0 || b_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready a=%b b=%b want 0/1", a_in_ready, b_in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; kill_valid = 1'b0;
    n_tests++; if (a_occ !== 2'd0 || b_occ !== 3'd0 || a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear occ=%0d/%0d valid=%b/%b want 0", a_occ, b_occ, a_out_valid, b_out_valid); end
    n_tests++; if (a_busy !== 1'b1 || b_busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_hi a=%b b=%b want 1", a_busy, b_busy); end
    in_valid = 1'b0; #1;
    n_tests++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_lo a=%b b=%b want 0", a_busy, b_busy); end
    @(posedge clk); #1;
    n_tests++; if (b_occ !== 3'd0 || b_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop occ=%0d valid=%b want 0", b_occ, b_out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_tag = TW'(c); in_data = dat[c];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_tests++; if (b_occ !== 3'd3) begin n_fail++; $display("FAIL mid_pre_occ got %0d want 3", b_occ); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (b_out_valid !== 1'b0 || b_occ !== 3'd0 || b_in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset valid=%b occ=%0d ready=%b want 0/0/1", b_out_valid, b_occ, b_in_ready); end
    n_tests++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_a valid=%b occ=%0d ready=%b want 0/0/1", a_out_valid, a_occ, a_in_ready); end
  endtask

  task automatic test_passthrough();
    logic exp_v;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      in_valid = $urandom_range(0, 1); in_tag = TW'($urandom_range(0, 3)); in_data = {$urandom, $urandom, $urandom};
      kill_valid = ($urandom_range(0, 2) == 0); kill_tag = TW'($urandom_range(0, 3));
      flush = ($urandom_range(0, 5) == 0); out_ready = $urandom_range(0, 1);
      @(negedge clk);
      exp_v = in_valid && !flush && !(kill_valid && in_tag == kill_tag);
      n_tests++; if (z_out_valid !== exp_v || z_out_tag !== in_tag || z_out_data !== in_data) begin n_fail++; $display("FAIL pass_out c=%0d valid=%b want %b", c, z_out_valid, exp_v); end
      n_tests++; if (z_in_ready !== out_ready || z_occ !== 1'b0 || z_busy !== in_valid) begin n_fail++; $display("FAIL pass_ctrl c=%0d ready=%b occ=%0d busy=%b", c, z_in_ready, z_occ, z_busy); end
      @(posedge clk); #1;
    end
  endtask

  task automatic model_upd(input int k, input logic acc, input logic del);
    ent_t q[$];
    ent_t e;
    if (k == 0) q = qa; else q = qb;
    if (flush) begin
      q.delete();
    end else begin
      if (del && q.size() > 0) void'(q.pop_front());
      if (kill_valid) begin
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].tag == kill_tag) q.delete(i);
      end
      if (acc && !(kill_valid && in_tag == kill_tag)) begin
        e.tag = in_tag; e.data = in_data;
        q.push_back(e);
      end
    end
    if (k == 0) qa = q; else qb = q;
  endtask

  task automatic test_random();
    logic acc_a, del_a, acc_b, del_b;
    do_reset();
    qa.delete(); qb.delete();
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0); in_tag = TW'($urandom); in_data = {$urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0); kill_valid = ($urandom_range(0, 15) == 0); kill_tag = TW'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      n_tests++; if (a_in_ready !== (out_ready || qa.size() < 2)) begin n_fail++; $display("FAIL rnd_a_ready c=%0d got %b size=%0d", c, a_in_ready, qa.size()); end
      n_tests++; if (a_busy !== (in_valid || qa.size() != 0) || b_busy !== (in_valid || qb.size() != 0)) begin n_fail++; $display("FAIL rnd_busy c=%0d a=%b b=%b", c, a_busy, b_busy); end
      if (a_out_valid) begin
        n_tests++; if (qa.size() == 0 || a_out_tag !== qa[0].tag || a_out_data !== qa[0].data) begin n_fail++; $display("FAIL rnd_a_out c=%0d tag=%0d size=%0d", c, a_out_tag, qa.size()); end
      end
      if (b_out_valid) begin
        n_tests++; if (qb.size() == 0 || b_out_tag !== qb[0].tag || b_out_data !== qb[0].data) begin n_fail++; $display("FAIL rnd_b_out c=%0d tag=%0d size=%0d", c, b_out_tag, qb.size()); end
      end
      acc_a = in_valid & a_in_ready; del_a = a_out_valid & out_ready;
      acc_b = in_valid & b_in_ready; del_b = b_out_valid & out_ready;
      @(posedge clk); #1;
      model_upd(0, acc_a, del_a);
      model_upd(1, acc_b, del_b);
      n_tests++; if (int'(a_occ) != qa.size() || int'(b_occ) != qb.size()) begin n_fail++; $display("FAIL rnd_occ c=%0d a=%0d/%0d b=%0d/%0d", c, a_occ, qa.size(), b_occ, qb.size()); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) dat[i] = {$urandom, $urandom, $urandom};
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_streaming();
    test_stall_fill();
    test_bubble_collapse();
    test_kill();
    test_flush_kill();
    test_reset_mid();
    test_passthrough();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
